// File: rtl/vrf_read_stage_if.sv
// Signal bundle of the VRF read stage: beat input, VRF read port, consumer output and status.
// The stage itself connects through the slave modport.
interface vrf_read_stage_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5,
   parameter int OFF_WIDTH  = 8
);
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] in_addr;
   logic [OFF_WIDTH-1:0]  in_off;
   logic                  in_start;
   logic                  in_end;
   logic                  vrf_rd_en;
   logic [ADDR_WIDTH-1:0] vrf_rd_addr;
   logic [OFF_WIDTH-1:0]  vrf_rd_off;
   logic [DATA_WIDTH-1:0] vrf_rd_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [OFF_WIDTH-1:0]  out_off;
   logic                  out_start;
   logic                  out_end;
   logic                  busy;
   logic                  group_done;

   modport master (
      output flush, in_valid, in_addr, in_off, in_start, in_end, vrf_rd_data, out_ready,
      input  in_ready, vrf_rd_en, vrf_rd_addr, vrf_rd_off,
      input  out_valid, out_data, out_off, out_start, out_end, busy, group_done
   );

   modport slave (
      input  flush, in_valid, in_addr, in_off, in_start, in_end, vrf_rd_data, out_ready,
      output in_ready, vrf_rd_en, vrf_rd_addr, vrf_rd_off,
      output out_valid, out_data, out_off, out_start, out_end, busy, group_done
   );
endinterface

// File: rtl/vrf_read_stage.sv
// VRF read stage: issues one VRF read per accepted beat, pairs the returning data with the
// beat's tag one cycle later and buffers it in a credit-protected output FIFO.
module vrf_read_stage #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5,
   parameter int OFF_WIDTH  = 8,
   parameter int DEPTH      = 4
) (
   input logic               clk,
   input logic               rst,
   vrf_read_stage_if.slave   bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [OFF_WIDTH-1:0] off;
      logic                 start;
      logic                 end_flag;
   } tag_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      tag_t                  tag;
   } entry_t;

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             inflight;
   tag_t             pend_tag;
   logic             group_done_q;

   logic             accept;
   logic             push;
   logic             pop;
   logic             not_empty;
   entry_t           head;

   // The in-flight beat already owns a FIFO slot, so credit counts it alongside count.
   // Reset also gates the ready so nothing is requested while the stage is held.
   assign bus.in_ready = ~rst & ~bus.flush & ((count + CNT_W'(inflight)) < CNT_W'(DEPTH));
   assign accept       = bus.in_valid & bus.in_ready;

   assign bus.vrf_rd_en   = accept;
   assign bus.vrf_rd_addr = bus.in_addr;
   assign bus.vrf_rd_off  = bus.in_off;

   assign not_empty = (count != '0);
   assign push      = inflight & ~bus.flush;
   assign pop       = not_empty & bus.out_ready & ~bus.flush;
   assign head      = mem[rd_ptr];

   assign bus.out_valid  = not_empty;
   assign bus.out_data   = head.data;
   assign bus.out_off    = head.tag.off;
   assign bus.out_start  = head.tag.start;
   assign bus.out_end    = head.tag.end_flag;
   assign bus.busy       = inflight | not_empty;
   assign bus.group_done = group_done_q;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         inflight     <= 1'b0;
         pend_tag     <= '0;
         group_done_q <= 1'b0;
      end else if (bus.flush) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         inflight     <= 1'b0;
         group_done_q <= 1'b0;
      end else begin
         inflight     <= accept;
         group_done_q <= pop & head.tag.end_flag;
         if (accept) begin
            pend_tag <= '{off: bus.in_off, start: bus.in_start, end_flag: bus.in_end};
         end
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // NOTE: the data array has no reset; an entry is meaningful only between rd_ptr and wr_ptr.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{data: bus.vrf_rd_data, tag: pend_tag};
      end
   end
endmodule

// File: tb/tb_vrf_read_stage.sv
// Self-checking bench for vrf_read_stage: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based model of the stage's externally visible behaviour.
module tb_vrf_read_stage;
   localparam int DW    = 64;
   localparam int AW    = 5;
   localparam int OW    = 8;
   localparam int DEPTH = 4;

   typedef struct {
      logic [DW-1:0] data;
      logic [OW-1:0] off;
      logic          s;
      logic          e;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   vrf_read_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OFF_WIDTH(OW)) bus ();

   vrf_read_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OFF_WIDTH(OW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: buffered beats, the beat whose read is outstanding, pending pulse.
   beat_t         model_q[$];
   bit            pend_v;
   beat_t         pend;
   logic [AW-1:0] pend_addr;
   bit            gd_exp;

   // VRF responder state: what the DUT requested last cycle.
   bit            rd_pend;
   logic [AW-1:0] rd_addr_q;
   logic [OW-1:0] rd_off_q;

   // Observation counters for the directed scenarios.
   int acc_cnt, gd_cnt, pop_cnt, rdy_low_cnt;
   logic [DW-1:0] last_pop_data;
   logic [OW-1:0] last_pop_off;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] vrf_word(input logic [AW-1:0] a, input logic [OW-1:0] o);
      if (a == 5'd3 && o == 8'h05) return 64'h0000_0000_DEAD_BEEF;
      return {(32'(a) * 32'h9E37_79B1) ^ 32'(o), (32'(o) * 32'h85EB_CA6B) + 32'(a)};
   endfunction

   task automatic clear_counters();
      acc_cnt = 0; gd_cnt = 0; pop_cnt = 0; rdy_low_cnt = 0;
   endtask

   task automatic model_clear();
      model_q.delete();
      pend_v  = 1'b0;
      gd_exp  = 1'b0;
      rd_pend = 1'b0;
   endtask

   // One clock cycle: drive at the falling edge, check 1 time unit later, advance the model.
   task automatic cycle(input bit iv, input logic [AW-1:0] addr, input logic [OW-1:0] off,
                        input bit st, input bit en, input bit ordy, input bit fl);
      bit    exp_ready, exp_acc, exp_valid, do_pop;
      beat_t nb;
      @(negedge clk);
      bus.in_valid  = iv;
      bus.in_addr   = addr;
      bus.in_off    = off;
      bus.in_start  = st;
      bus.in_end    = en;
      bus.out_ready = ordy;
      bus.flush     = fl;
      bus.vrf_rd_data = rd_pend ? vrf_word(rd_addr_q, rd_off_q) : {$urandom, $urandom};
      #1;
      exp_ready = !fl && (model_q.size() + int'(pend_v)) < DEPTH;
      exp_acc   = iv && exp_ready;
      exp_valid = model_q.size() != 0;
      check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
      check("vrf_rd_en", 64'(bus.vrf_rd_en), 64'(exp_acc));
      if (exp_acc) begin
         check("vrf_rd_addr", 64'(bus.vrf_rd_addr), 64'(addr));
         check("vrf_rd_off", 64'(bus.vrf_rd_off), 64'(off));
      end
      check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
      if (exp_valid) begin
         check("out_data", bus.out_data, model_q[0].data);
         check("out_off", 64'(bus.out_off), 64'(model_q[0].off));
         check("out_start", 64'(bus.out_start), 64'(model_q[0].s));
         check("out_end", 64'(bus.out_end), 64'(model_q[0].e));
      end
      check("busy", 64'(bus.busy), 64'(pend_v || exp_valid));
      check("group_done", 64'(bus.group_done), 64'(gd_exp));

      acc_cnt     += int'(bus.vrf_rd_en);
      gd_cnt      += int'(bus.group_done);
      rdy_low_cnt += int'(!bus.in_ready);
      if (bus.out_valid && ordy && !fl) begin
         pop_cnt++;
         last_pop_data = bus.out_data;
         last_pop_off  = bus.out_off;
      end
      rd_pend   = bus.vrf_rd_en;
      rd_addr_q = bus.vrf_rd_addr;
      rd_off_q  = bus.vrf_rd_off;

      if (fl) begin
         model_q.delete();
         pend_v = 1'b0;
         gd_exp = 1'b0;
      end else begin
         do_pop = exp_valid && ordy;
         gd_exp = do_pop && model_q[0].e;
         if (do_pop) void'(model_q.pop_front());
         if (pend_v) begin
            pend.data = vrf_word(pend_addr, pend.off);
            model_q.push_back(pend);
         end
         pend_v    = exp_acc;
         nb.data   = '0;
         nb.off    = off;
         nb.s      = st;
         nb.e      = en;
         pend      = nb;
         pend_addr = addr;
      end
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, ordy, 1'b0);
   endtask

   // Asserts reset between clock edges, checks the outputs react at once, then releases it.
   task automatic async_reset();
      #2;
      rst = 1'b1;
      #1;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_vrf_rd_en", 64'(bus.vrf_rd_en), 64'd0);
      check("rst_group_done", 64'(bus.group_done), 64'd0);
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      model_clear();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_release_in_ready", 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_off = '0;
      bus.in_start = 1'b0; bus.in_end = 1'b0; bus.out_ready = 1'b0; bus.vrf_rd_data = '0;
      model_clear();
      clear_counters();

      // Reset state.
      #3;
      check("reset_in_ready", 64'(bus.in_ready), 64'd0);
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_group_done", 64'(bus.group_done), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle(2, 1'b1);

      // 8-beat group streamed with out_ready held high.
      clear_counters();
      for (int i = 0; i < 8; i++)
         cycle(1'b1, AW'(i + 8), OW'(i), i == 0, i == 7, 1'b1, 1'b0);
      check("grp8_ready_low", 64'(rdy_low_cnt), 64'd0);
      idle(4, 1'b1);
      check("grp8_accepted", 64'(acc_cnt), 64'd8);
      check("grp8_popped", 64'(pop_cnt), 64'd8);
      check("grp8_group_done", 64'(gd_cnt), 64'd1);

      // Back-pressure: only DEPTH beats fit, then drain in order.
      clear_counters();
      for (int i = 0; i < 8; i++)
         cycle(1'b1, AW'(i), OW'(8'h40 + i), i == 0, 1'b0, 1'b0, 1'b0);
      check("stall_accepted", 64'(acc_cnt), 64'd4);
      check("stall_popped", 64'(pop_cnt), 64'd0);
      idle(6, 1'b1);
      check("stall_drained", 64'(pop_cnt), 64'd4);
      check("stall_last_off", 64'(last_pop_off), 64'h43);

      // Full FIFO with continuous traffic in and out: pointers wrap several times.
      idle(6, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, AW'(i), OW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2, 1'b0);
      clear_counters();
      for (int i = 0; i < 14; i++)
         cycle(1'b1, AW'(i + 16), OW'(8'h80 + i), 1'b0, i == 13, 1'b1, 1'b0);
      idle(8, 1'b1);
      check("full_popped", 64'(pop_cnt), 64'(4 + acc_cnt));

      // Flush the cycle after an accept, with two beats buffered.
      clear_counters();
      cycle(1'b1, 5'd1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 5'd2, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2, 1'b0);
      cycle(1'b1, 5'd4, 8'h13, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 5'd5, 8'h14, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(4, 1'b1);
      check("flush_popped", 64'(pop_cnt), 64'd0);
      check("flush_group_done", 64'(gd_cnt), 64'd0);

      // Asynchronous reset in the middle of a burst, then one single-beat group.
      for (int i = 0; i < 5; i++) cycle(1'b1, AW'(i), OW'(i), 1'b0, 1'b0, i[0], 1'b0);
      async_reset();
      clear_counters();
      cycle(1'b1, 5'd3, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(4, 1'b1);
      check("single_popped", 64'(pop_cnt), 64'd1);
      check("single_data", last_pop_data, 64'h0000_0000_DEAD_BEEF);
      check("single_off", 64'(last_pop_off), 64'h05);
      check("single_group_done", 64'(gd_cnt), 64'd1);

      // Random traffic.
      for (int i = 0; i < 600; i++)
         cycle($urandom_range(0, 9) < 7, AW'($urandom), OW'($urandom), $urandom_range(0, 7) == 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
      idle(8, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/vrf_read_stage.md
VRF_READ_STAGE -- requirements
Module: vrf_read_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning the vector register file (VRF) read data width per beat.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning the register address width (32 vector registers).
REQ-003 SHALL have parameter OFF_WIDTH, default 8, meaning the beat offset width within a register.
REQ-004 SHALL have parameter DEPTH, default 4, meaning the output FIFO entries; it is a power of 2 and at least 2.
REQ-005 SHALL have port: clk  input  1  clock, all state on the rising edge.
REQ-006 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port: flush  input  1  synchronous discard of all buffered and in-flight beats.
REQ-008 SHALL have ports in_valid, in_ready  input/output  1  beat handshake from the address generator.
REQ-009 SHALL have ports in_addr  input  ADDR_WIDTH, in_off  input  OFF_WIDTH, and in_start, in_end  input  1 each, carrying the beat register, offset and group start/end flags.
REQ-010 SHALL have ports vrf_rd_en  output  1, vrf_rd_addr  output  ADDR_WIDTH and vrf_rd_off  output  OFF_WIDTH, forming the VRF read request.
REQ-011 SHALL have port: vrf_rd_data  input  DATA_WIDTH, valid exactly one cycle after vrf_rd_en.
REQ-012 SHALL have ports out_valid  output  1 and out_ready  input  1, forming the consumer handshake.
REQ-013 SHALL have ports out_data  output  DATA_WIDTH, out_off  output  OFF_WIDTH, and out_start, out_end  output  1 each.
REQ-014 SHALL have port: busy  output  1, high when any beat is in flight or buffered.
REQ-015 SHALL have port: group_done  output  1, a one-cycle pulse when a beat with end=1 is handed out.

Function
REQ-016 SHALL accept a beat (push) when in_valid and in_ready are both high in the same cycle.
REQ-017 SHALL drive in_ready = ~flush & ((count + inflight) < DEPTH), where count is the FIFO occupancy and inflight (0/1) is a beat accepted in the previous cycle; in_ready SHALL NOT depend combinationally on out_ready.
REQ-018 SHALL drive vrf_rd_en = in_valid & in_ready, with vrf_rd_addr = in_addr and vrf_rd_off = in_off, all combinationally in the same cycle.
REQ-019 SHALL register the accepted beat's off, start and end flags together with inflight=1; in the next cycle it SHALL write {vrf_rd_data, off, start, end} into the FIFO tail.
REQ-020 SHALL set latency so that a beat accepted at cycle T gives out_valid at cycle T+2 at the earliest.
REQ-021 SHALL sustain 1 beat/cycle when out_ready is held high.
REQ-022 SHALL drive out_valid = (count != 0), with out_* taken combinationally from the FIFO head; a pop occurs on out_valid & out_ready.
REQ-023 SHALL advance the FIFO read/write pointers modulo DEPTH (wrap-around), and support push and pop in the same cycle at any occupancy, including full; count SHALL then be unchanged.
REQ-024 SHALL make the credit rule of REQ-017 guarantee no overflow; no write SHALL occur when count == DEPTH.
REQ-025 SHALL treat a pop while empty as impossible, since out_valid=0.
REQ-026 SHALL hold out_data and the out_* flags stable while out_valid=1 and out_ready=0.
REQ-027 SHALL assert group_done, registered, in the cycle after a pop whose out_end=1; a single beat with start=end=1 SHALL also produce exactly one pulse.
REQ-028 SHALL drive busy = inflight | (count != 0).
REQ-029 SHALL, on flush=1, force in_ready=0 that cycle and, at the clock edge, zero count, both pointers and inflight; vrf_rd_data returning for a discarded beat SHALL be ignored; group_done SHALL be 0 in the cycle after the flush.
REQ-030 SHALL give flush priority over a simultaneous pop and over a pending write.

Reset
REQ-031 SHALL, while rst=1 and independent of clk, hold count=0, both pointers=0, inflight=0 and group_done=0, so that out_valid=0, busy=0, in_ready=0 and vrf_rd_en=0.
REQ-032 SHALL, after rst deasserts, raise in_ready=1 on the first cycle; a reset mid-burst SHALL drop all beats with no output of partial data.
REQ-033 SHALL NOT reset FIFO data storage; only pointers, count and flags are reset.

Verification
REQ-034 SHALL cover: 8-beat group (in_start on beat 0, in_end on beat 7) with out_ready=1 -> 8 outputs in order at T+2..T+9, in_ready=1 throughout, group_done one pulse at T+10.
REQ-035 SHALL cover: out_ready=0 with continuous in_valid -> exactly 4 beats accepted, in_ready=0 afterwards, out_data stable; out_ready=1 then -> 4 beats drain in order and in_ready returns.
REQ-036 SHALL cover: full FIFO (count=4) with out_ready=1 and in_valid=1 -> one pop per cycle, new pushes credited, count never exceeds 4, pointers wrap cleanly past index 3.
REQ-037 SHALL cover: flush asserted the cycle after a beat is accepted, with 2 beats buffered -> next cycle out_valid=0 and busy=0, the returning vrf_rd_data is not emitted, and no group_done.
REQ-038 SHALL cover: rst pulse asserted asynchronously mid-burst -> out_valid=0, busy=0 and in_ready=0 immediately; after release, a new single beat (start=end=1, off=0x05, data 0xDEADBEEF) emerges with out_off=0x05 and exactly one group_done.
